// File: rtl/cc3000_spi_slave.sv
// SPI mode-1 slave for the CC3000 host link: SPI pins are oversampled on SYSCLK,
// with one-byte transmit holding register and byte-wide receive output.
module cc3000_spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
    input  logic       SYSCLK,
    input  logic       NSYSRESET,
    input  logic       SPI_CLK,
    input  logic       SPI_SS,
    input  logic       SPI_DI,
    output logic       SPI_DO,
    output logic       SPI_DO_OE,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       irq_n,
    output logic       underrun,
    output logic       aborted,
    output logic       frame_done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] clk_sync, ss_sync, di_sync;
    logic                   clk_d, ss_d;
    logic                   clk_s, ss_s, di_s;
    logic                   clk_rise, clk_fall, ss_rise, ss_fall;

    logic [7:0] tx_sh, rx_sh, hold_data;
    logic       hold_full;
    logic [2:0] bitcnt;

    logic do_start, do_load, do_shl, do_samp, do_abort, do_done;

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign ss_s  = ss_sync[SYNC_STAGES-1];
    assign di_s  = di_sync[SYNC_STAGES-1];

    assign clk_rise = clk_s & ~clk_d;
    assign clk_fall = ~clk_s & clk_d;
    assign ss_rise  = ss_s & ~ss_d;
    assign ss_fall  = ~ss_s & ss_d;

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            clk_sync <= '0;
            ss_sync  <= '0;
            di_sync  <= '0;
            clk_d    <= 1'b0;
            ss_d     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], SPI_CLK};
            ss_sync  <= {ss_sync[SYNC_STAGES-2:0], SPI_SS};
            di_sync  <= {di_sync[SYNC_STAGES-2:0], SPI_DI};
            clk_d    <= clk_s;
            ss_d     <= ss_s;
        end
    end

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) state <= IDLE;
        else            state <= state_nxt;
    end

    // SS edges win over SCK edges; SS rising while IDLE (e.g. after a reset
    // that cut a frame) is not a frame end and produces no pulse.
    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        do_load   = 1'b0;
        do_shl    = 1'b0;
        do_samp   = 1'b0;
        do_abort  = 1'b0;
        do_done   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt = SHIFT;
                    do_start  = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                    do_done   = 1'b1;
                    do_abort  = (bitcnt != 3'd0);
                end else if (clk_rise) begin
                    if (bitcnt == 3'd0) do_load = 1'b1;
                    else                do_shl  = 1'b1;
                end else if (clk_fall) begin
                    do_samp = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            tx_sh      <= '0;
            rx_sh      <= '0;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            bitcnt     <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            underrun   <= 1'b0;
            aborted    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            underrun   <= 1'b0;
            aborted    <= do_abort;
            frame_done <= do_done;

            if (do_start) bitcnt <= 3'd0;

            if (do_load) begin
                if (hold_full) begin
                    tx_sh <= hold_data;
                end else begin
                    tx_sh    <= IDLE_BYTE;
                    underrun <= 1'b1;
                end
            end else if (do_shl) begin
                tx_sh <= {tx_sh[6:0], 1'b0};
            end

            if (do_samp) begin
                rx_sh  <= {rx_sh[6:0], di_s};
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                    rx_data  <= {rx_sh[6:0], di_s};
                    rx_valid <= 1'b1;
                end
            end

            // A byte accepted while the slot is being filled from an empty
            // register waits for the next slot rather than bypassing.
            if (do_load && hold_full) begin
                hold_full <= 1'b0;
            end else if (tx_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end
        end
    end

    assign tx_ready  = ~hold_full;
    assign irq_n     = ~hold_full;
    assign SPI_DO    = (state == SHIFT) ? tx_sh[7] : 1'b0;
    assign SPI_DO_OE = (state == SHIFT);

endmodule
